// File: rtl/pc_control.sv
// Program counter sequencer: RUN/FLUSH/HALT/FAULT control of the fetch address.
// Optional taken-branch counter enabled by defining PC_CONTROL_TAKEN_CNT_EN.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        restart,
  input  logic        branch_valid,
  input  logic        PC_src,
  input  logic        branch_err,
  input  logic [15:0] target,
  output logic [15:0] PC,
  output logic [15:0] PC_plus2,
  output logic        fetch_valid,
  output logic        halted,
  output logic        err,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;

  assign PC       = pc_q;
  assign PC_plus2 = pc_q + 16'd2;

  // Status outputs depend on the registered state only, never on inputs.
  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign err         = (state_q == FAULT);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      RUN: begin
        // Priority order matters: faults beat halt, halt beats a taken branch,
        // and a taken branch beats stall.
        if (branch_valid && branch_err) begin
          state_d = FAULT;
        end else if (branch_valid && PC_src && target[0]) begin
          state_d = FAULT;
        end else if (halt) begin
          state_d = HALT;
        end else if (branch_valid && PC_src) begin
          pc_d    = target;
          state_d = FLUSH;
        end else if (!stall) begin
          pc_d = PC_plus2;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      HALT: begin
        if (restart) begin
          pc_d    = PC_plus2;
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from values sampled at the same edge.
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_CONTROL_TAKEN_CNT_EN
  logic        take_branch;
  logic [15:0] cnt_q, cnt_d;

  // Mirrors the taken-branch rule: only counts when the redirect really happens.
  assign take_branch = (state_q == RUN) && branch_valid && PC_src && !branch_err
                       && !target[0] && !halt;

  always_comb begin
    cnt_d = cnt_q;
    if (take_branch && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed scenarios then randomized
// traffic compared against a behavioural model of the fetch sequencer.
module tb_pc_control;

`ifdef PC_CONTROL_TAKEN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall, halt, restart, branch_valid, PC_src, branch_err;
  logic [15:0] target;
  logic [15:0] PC, PC_plus2, taken_cnt;
  logic        fetch_valid, halted, err;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: PC as an integer plus three mode flags.
  int m_pc;
  bit m_flushing, m_halted, m_faulted;
  int m_taken;

  pc_control #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt         (halt),
    .restart      (restart),
    .branch_valid (branch_valid),
    .PC_src       (PC_src),
    .branch_err   (branch_err),
    .target       (target),
    .PC           (PC),
    .PC_plus2     (PC_plus2),
    .fetch_valid  (fetch_valid),
    .halted       (halted),
    .err          (err),
    .taken_cnt    (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; restart = 0;
    branch_valid = 0; PC_src = 0; branch_err = 0;
    target = 16'h0000;
  endtask

  task automatic model_reset();
    m_pc = 0; m_flushing = 0; m_halted = 0; m_faulted = 0; m_taken = 0;
  endtask

  // One clock of the sequencer rules, applied to the current inputs.
  task automatic model_step();
    if (m_faulted) begin
      // stuck until reset
    end else if (m_flushing) begin
      m_flushing = 0;
    end else if (m_halted) begin
      if (restart) begin
        m_pc = (m_pc + 2) % 65536;
        m_halted = 0;
      end
    end else if (branch_valid && branch_err) begin
      m_faulted = 1;
    end else if (branch_valid && PC_src && (target % 2 == 1)) begin
      m_faulted = 1;
    end else if (halt) begin
      m_halted = 1;
    end else if (branch_valid && PC_src) begin
      m_pc = int'(target);
      m_flushing = 1;
      m_taken++;
    end else if (!stall) begin
      m_pc = (m_pc + 2) % 65536;
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] exp_cnt;
    exp_cnt = !CNT_EN ? 16'h0000 : (m_taken > 65535 ? 16'hFFFF : 16'(m_taken));
    check({tag, ".PC"},          PC,                 16'(m_pc));
    check({tag, ".PC_plus2"},    PC_plus2,           16'((m_pc + 2) % 65536));
    check({tag, ".fetch_valid"}, {15'b0, fetch_valid},
          {15'b0, !(m_flushing || m_halted || m_faulted)});
    check({tag, ".halted"},      {15'b0, halted},    {15'b0, m_halted});
    check({tag, ".err"},         {15'b0, err},       {15'b0, m_faulted});
    check({tag, ".taken_cnt"},   taken_cnt,          exp_cnt);
  endtask

  // Inputs are held across the edge; outputs are sampled 1ns after it.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Assert reset mid-cycle, check its immediate effect, release at the next negedge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic branch_to(input logic [15:0] t);
    branch_valid = 1; PC_src = 1; target = t;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    check_model("reset");
    check("reset.PC_const", PC, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running fetch from reset.
    for (int i = 1; i <= 4; i++) begin
      tick("free");
      check("free.PC_const", PC, 16'(2 * i));
      check("free.fv_const", {15'b0, fetch_valid}, 16'h0001);
    end

    // Taken branch overrides stall; one flush bubble then fetch resumes.
    do_reset("rst_run");
    for (int i = 0; i < 3; i++) tick("to6");
    check("at6", PC, 16'h0006);
    branch_to(16'h0040); stall = 1;
    tick("br40");
    check("br40.PC", PC, 16'h0040);
    check("br40.fv", {15'b0, fetch_valid}, 16'h0000);
    clear_inputs();
    tick("br40.fetch");
    check("br40.fetch.fv", {15'b0, fetch_valid}, 16'h0001);
    tick("br40.next");
    check("br40.next.PC", PC, 16'h0042);

    // HALT holds PC until restart, ignoring branch and stall.
    branch_to(16'h0020);
    tick("br20");
    clear_inputs();
    tick("at20");
    halt = 1;
    tick("halt");
    check("halt.halted", {15'b0, halted}, 16'h0001);
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      stall = i[0]; branch_valid = 1; PC_src = 1; target = 16'h0100;
      tick("halted");
      check("halted.PC", PC, 16'h0020);
    end
    clear_inputs();
    restart = 1;
    tick("restart");
    check("restart.PC", PC, 16'h0022);
    check("restart.halted", {15'b0, halted}, 16'h0000);
    clear_inputs();

    // Reset aborts HALT.
    halt = 1;
    tick("halt2");
    clear_inputs();
    do_reset("rst_halt");

    // Illegal branch code faults and sticks until reset.
    for (int i = 0; i < 8; i++) tick("to10");
    check("at10", PC, 16'h0010);
    branch_valid = 1; branch_err = 1;
    tick("fault");
    check("fault.err", {15'b0, err}, 16'h0001);
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      restart = i[0]; halt = ~i[0];
      tick("faulted");
      check("faulted.PC", PC, 16'h0010);
    end
    clear_inputs();
    do_reset("rst_fault");
    check("rst_fault.err", {15'b0, err}, 16'h0000);

    // Odd target faults with PC unchanged.
    branch_to(16'h0031);
    tick("odd");
    check("odd.err", {15'b0, err}, 16'h0001);
    check("odd.PC", PC, 16'h0000);
    clear_inputs();
    do_reset("rst_odd");

    // Wrap past FFFE.
    branch_to(16'hFFFC);
    tick("brFFFC");
    clear_inputs();
    tick("atFFFC");
    tick("atFFFE");
    check("wrap.FFFE", PC, 16'hFFFE);
    tick("wrap0");
    check("wrap.0000", PC, 16'h0000);
    check("wrap.err", {15'b0, err}, 16'h0000);
    check("wrap.cnt", taken_cnt, CNT_EN ? 16'h0001 : 16'h0000);

    // Reset aborts FLUSH.
    branch_to(16'h0200);
    tick("br200");
    clear_inputs();
    do_reset("rst_flush");
    check("rst_flush.fv", {15'b0, fetch_valid}, 16'h0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 3) == 0);
      halt         = ($urandom_range(0, 15) == 0);
      restart      = ($urandom_range(0, 3) == 0);
      branch_valid = ($urandom_range(0, 2) == 0);
      PC_src       = 1'($urandom_range(0, 1));
      branch_err   = ($urandom_range(0, 31) == 0);
      target       = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 15) == 0) target[0] = 1'b1;
      if ($urandom_range(0, 39) == 0) do_reset("rand_rst");
      else tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
